afifo_wr_packer: RTL and testbench

Write-side producer for the asynchronous FIFO wrapper. Accepts a narrow valid/ready beat stream in the WClk domain and packs R beats per FIFO word. It terminates packets on `in_last` (zero-padded partial word) or on an explicit flush. It drives the FIFO write port (`we`/`d`) and honours `wfull` backpressure through a single registered output buffer, sustaining one beat per cycle.

---
 rtl/afifo_pkg.sv | 24 ++
 rtl/afifo_wr_packer.sv | 104 ++++++++++
 tb/tb_afifo_wr_packer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// Shared definitions for the asynchronous FIFO wrapper: word-width helper,
// sideband struct and field offsets of the packed FIFO word.
package afifo_pkg;

    localparam int IW_DEF = 32;
    localparam int R_DEF  = 4;
    localparam int CW_DEF = $clog2(R_DEF + 1);
    localparam int DW_DEF = IW_DEF * R_DEF;

    // FIFO word layout: {last, nbeats, data}
    localparam int DATA_LSB   = 0;
    localparam int NBEATS_LSB = DW_DEF;
    localparam int LAST_BIT   = DW_DEF + CW_DEF;

    typedef struct packed {
        logic              last;
        logic [CW_DEF-1:0] nbeats;
    } afifo_sb_t;

    function automatic int fw(input int iw, input int r);
        return iw * r + $clog2(r + 1) + 1;
    endfunction

endpackage

// File: rtl/afifo_wr_packer.sv
// Write-side packer: gathers R narrow beats per FIFO word, terminates on last
// or flush, and feeds the FIFO through one registered output buffer.
module afifo_wr_packer
    import afifo_pkg::*;
#(
    parameter int IW = 32,
    parameter int R  = 4,
    parameter int DW = IW * R,
    parameter int CW = $clog2(R + 1),
    parameter int FW = fw(IW, R)
) (
    input  logic          WClk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    input  logic          in_last,
    input  logic          flush,
    output logic          fifo_we,
    output logic [FW-1:0] fifo_d,
    input  logic          fifo_wfull,
    input  logic          fifo_wafull,
    output logic [15:0]   word_cnt,
    output logic [15:0]   pkt_cnt
);

    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [FW-1:0] ob_q, ob_d;
    logic          ob_vld_q, ob_vld_d;
    logic [15:0]   word_cnt_q, word_cnt_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;

    logic          ob_free;
    logic          accept;
    logic          complete;
    logic          flush_go;
    logic [DW-1:0] acc_ins;

    // Almost-full is informational only at this level.
    logic unused_wafull;
    assign unused_wafull = fifo_wafull;

    // Buffer is free now, or it drains to the FIFO this very cycle.
    assign ob_free  = ~ob_vld_q | ~fifo_wfull;
    assign in_ready = ob_free;
    assign fifo_we  = ob_vld_q & ~fifo_wfull;
    assign fifo_d   = ob_q;
    assign word_cnt = word_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;

    assign accept   = in_valid & ob_free;
    assign complete = accept & ((idx_q == CW'(R - 1)) | in_last);
    assign flush_go = flush & (idx_q != '0) & ~accept & ob_free;

    always_comb begin
        acc_ins = acc_q;
        for (int l = 0; l < R; l++) begin
            if (idx_q == CW'(l)) acc_ins[l*IW +: IW] = in_data;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        idx_d      = idx_q;
        ob_d       = ob_q;
        ob_vld_d   = ob_vld_q & ~fifo_we;
        word_cnt_d = word_cnt_q + 16'(fifo_we);
        pkt_cnt_d  = pkt_cnt_q + 16'(fifo_we & ob_q[FW-1]);
        if (complete) begin
            ob_d     = {in_last, idx_q + CW'(1), acc_ins};
            ob_vld_d = 1'b1;
            idx_d    = '0;
            acc_d    = '0;
        end else if (accept) begin
            acc_d = acc_ins;
            idx_d = idx_q + CW'(1);
        end else if (flush_go) begin
            ob_d     = {1'b0, idx_q, acc_q};
            ob_vld_d = 1'b1;
            idx_d    = '0;
            acc_d    = '0;
        end
    end

    always_ff @(posedge WClk or negedge rstn) begin
        if (!rstn) begin
            acc_q      <= '0;
            idx_q      <= '0;
            ob_q       <= '0;
            ob_vld_q   <= 1'b0;
            word_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            ob_q       <= ob_d;
            ob_vld_q   <= ob_vld_d;
            word_cnt_q <= word_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_afifo_wr_packer.sv
// Bench for afifo_wr_packer: beat driver with a packing model feeding an
// expected-word queue, compared against every FIFO write.
module tb_afifo_wr_packer;
    import afifo_pkg::*;

    localparam int IW = 32;
    localparam int R  = 4;
    localparam int DW = IW * R;
    localparam int CW = $clog2(R + 1);
    localparam int FW = DW + CW + 1;

    logic          WClk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_we;
    logic [FW-1:0] fifo_d;
    logic          fifo_wfull = 1'b0;
    logic          fifo_wafull = 1'b0;
    logic [15:0]   word_cnt;
    logic [15:0]   pkt_cnt;

    afifo_wr_packer #(.IW(IW), .R(R)) dut (
        .WClk(WClk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .flush(flush),
        .fifo_we(fifo_we), .fifo_d(fifo_d), .fifo_wfull(fifo_wfull), .fifo_wafull(fifo_wafull),
        .word_cnt(word_cnt), .pkt_cnt(pkt_cnt)
    );

    // clock / reset
    always #5 WClk = ~WClk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge WClk) cyc <= cyc + 1;

    logic [FW-1:0] exp_q[$];
    logic [DW-1:0] m_acc = '0;
    int            m_idx = 0;

    int wr_seen   = 0;
    bit b2b_on    = 1'b0;
    int b2b_n     = 0;
    int b2b_prev  = 0;
    int b2b_gaps  = 0;

    task automatic check(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_word(input logic last, input int nb, input logic [DW-1:0] d);
        logic [CW-1:0] nbv;
        nbv = CW'(nb);
        return {last, nbv, d};
    endfunction

    task automatic model_accept(input logic [IW-1:0] d, input logic l);
        m_acc[m_idx*IW +: IW] = d;
        if (m_idx == R - 1 || l) begin
            exp_q.push_back(mk_word(l, m_idx + 1, m_acc));
            m_acc = '0;
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    // driver: present one beat, wait (bounded) for acceptance
    task automatic send_beat(input logic [IW-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge WClk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge WClk);
            #1;
        end
        check("beat_accept_timeout", FW'(ok), FW'(1));
        if (ok) begin
            @(posedge WClk);
            #1;
            model_accept(d, l);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_flush();
        bit ok;
        ok = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge WClk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("flush_timeout", FW'(ok), FW'(1));
        @(posedge WClk);
        #1;
        flush = 1'b0;
        if (m_idx != 0) begin
            exp_q.push_back(mk_word(1'b0, m_idx, m_acc));
            m_acc = '0;
            m_idx = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge WClk);
        #1;
    endtask

    // scoreboard: every write must match the head of the expected queue
    always @(negedge WClk) begin
        if (rstn && fifo_we) begin
            wr_seen++;
            if (exp_q.size() == 0) check("unexpected_write", fifo_d, '0);
            else check("fifo_word", fifo_d, exp_q.pop_front());
            if (b2b_on) begin
                if (b2b_n > 0 && cyc != b2b_prev + 1) b2b_gaps++;
                b2b_prev = cyc;
                b2b_n++;
            end
        end
    end

    initial begin
        int acc_cnt;
        int wr_base;
        logic [15:0] pkt_base;

        // reset state
        #12;
        @(negedge WClk);
        check("rst_we", FW'(fifo_we), FW'(0));
        check("rst_d", fifo_d, '0);
        check("rst_ready", FW'(in_ready), FW'(1));
        check("rst_word_cnt", FW'(word_cnt), FW'(0));
        check("rst_pkt_cnt", FW'(pkt_cnt), FW'(0));
        @(posedge WClk);
        #1;
        rstn = 1'b1;
        idle(2);

        // single full packet, latency one cycle after the final accept
        send_beat(32'h11, 1'b0);
        send_beat(32'h22, 1'b0);
        send_beat(32'h33, 1'b0);
        send_beat(32'h44, 1'b1);
        @(negedge WClk);
        check("full_lat_we", FW'(fifo_we), FW'(1));
        check("full_word", fifo_d, {1'b1, 3'd4, 128'h00000044_00000033_00000022_00000011});
        idle(2);
        check("full_word_cnt", FW'(word_cnt), FW'(1));
        check("full_pkt_cnt", FW'(pkt_cnt), FW'(1));

        // short packet: upper lanes zero
        send_beat(32'hA, 1'b0);
        send_beat(32'hB, 1'b1);
        @(negedge WClk);
        check("short_word", fifo_d, {1'b1, 3'd2, 128'h0000000B_0000000A});
        idle(2);
        check("short_pkt_cnt", FW'(pkt_cnt), FW'(2));

        // flush of a 3-beat partial word
        send_beat(32'hC1, 1'b0);
        send_beat(32'hC2, 1'b0);
        send_beat(32'hC3, 1'b0);
        do_flush();
        @(negedge WClk);
        check("flush_word", fifo_d, {1'b0, 3'd3, 128'h000000C3_000000C2_000000C1});
        idle(2);
        check("flush_word_cnt", FW'(word_cnt), FW'(3));
        check("flush_pkt_cnt", FW'(pkt_cnt), FW'(2));

        // flush with nothing pending is a no-op
        wr_base = wr_seen;
        do_flush();
        idle(5);
        check("flush_noop_writes", FW'(wr_seen - wr_base), FW'(0));
        check("flush_noop_word_cnt", FW'(word_cnt), FW'(3));

        // backpressure: full for 10 cycles while 8 beats are offered
        fifo_wfull = 1'b1;
        wr_base = wr_seen;
        acc_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(acc_cnt);
            in_last  = (acc_cnt == 7);
            @(negedge WClk);
            if (in_ready) begin
                @(posedge WClk);
                #1;
                model_accept(32'h100 + 32'(acc_cnt), acc_cnt == 7);
                acc_cnt++;
            end else begin
                @(posedge WClk);
                #1;
            end
        end
        @(negedge WClk);
        check("bp_accepted", FW'(acc_cnt), FW'(4));
        check("bp_ready_low", FW'(in_ready), FW'(0));
        check("bp_no_write", FW'(wr_seen - wr_base), FW'(0));
        @(posedge WClk);
        #1;
        in_valid = 1'b0;
        fifo_wfull = 1'b0;
        for (int k = 4; k < 8; k++) send_beat(32'h100 + 32'(k), k == 7);
        idle(3);
        check("bp_writes", FW'(wr_seen - wr_base), FW'(2));
        check("bp_word_cnt", FW'(word_cnt), FW'(5));
        check("bp_pkt_cnt", FW'(pkt_cnt), FW'(3));

        // back-to-back single-beat packets
        pkt_base = pkt_cnt;
        b2b_on = 1'b1;
        for (int p = 0; p < 100; p++) send_beat(32'($urandom_range(0, 32'hFFFF)), 1'b1);
        idle(3);
        b2b_on = 1'b0;
        check("b2b_writes", FW'(b2b_n), FW'(100));
        check("b2b_gaps", FW'(b2b_gaps), FW'(0));
        check("b2b_pkt_delta", FW'(16'(pkt_cnt - pkt_base)), FW'(100));
        check("drain_empty", FW'(exp_q.size()), FW'(0));

        // reset mid-packet: partial word discarded
        send_beat(32'hD1, 1'b0);
        send_beat(32'hD2, 1'b0);
        rstn = 1'b0;
        exp_q.delete();
        m_acc = '0;
        m_idx = 0;
        @(negedge WClk);
        check("mid_rst_we", FW'(fifo_we), FW'(0));
        check("mid_rst_d", fifo_d, '0);
        check("mid_rst_ready", FW'(in_ready), FW'(1));
        check("mid_rst_word_cnt", FW'(word_cnt), FW'(0));
        check("mid_rst_pkt_cnt", FW'(pkt_cnt), FW'(0));
        @(posedge WClk);
        #1;
        rstn = 1'b1;
        idle(2);
        send_beat(32'hE1, 1'b1);
        @(negedge WClk);
        check("post_rst_lane0", fifo_d, {1'b1, 3'd1, 128'h000000E1});
        idle(3);
        check("post_rst_word_cnt", FW'(word_cnt), FW'(1));
        check("final_queue_empty", FW'(exp_q.size()), FW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
